// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output path and the SPI register map.
`timescale 1ns/1ps
package pwm_pkg;

    localparam int          PWM_CNT_W   = 8;
    localparam logic [7:0]  PWM_MAX     = 8'hFF;
    localparam int          NUM_OUT     = 16;
    localparam int          CLK_DIV_DEF = 3000;

    // SPI register addresses, shared with the SPI register block.
    localparam logic [7:0]  ADDR_EN_OUT_7_0  = 8'h00;
    localparam logic [7:0]  ADDR_EN_OUT_15_8 = 8'h01;
    localparam logic [7:0]  ADDR_EN_PWM_7_0  = 8'h02;
    localparam logic [7:0]  ADDR_EN_PWM_15_8 = 8'h03;
    localparam logic [7:0]  ADDR_PWM_DUTY    = 8'h04;

    // PWM level for a given count and duty. Full-scale duty is
    // constant high so there is no one-count gap at the end of a period.
    function automatic logic pwm_level_f(input logic [PWM_CNT_W-1:0] cnt,
                                         input logic [PWM_CNT_W-1:0] duty);
        return (duty == PWM_MAX) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler producing one count step every CLK_DIV clocks,
// and an 8-bit period counter. o_wrap marks the last clock of a period.
`timescale 1ns/1ps
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] o_cnt,
    output logic                 o_wrap
);

    // A one-clock division still needs a 1-bit prescaler that stays at 0.
    localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]     r_pre;
    logic [PWM_CNT_W-1:0] r_cnt;
    logic                 w_tick;

    assign w_tick = (r_pre == PRE_LAST);
    assign o_cnt  = r_cnt;
    assign o_wrap = w_tick && (r_cnt == PWM_MAX);

    // Prescaler wraps on tick; the period counter advances on tick and rolls 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_scheduler.sv
// Drives the user outputs from the register-block enables and duty cycle.
// The duty cycle is shadowed and only taken at a period boundary so that
// pulses are never cut short or stretched mid-period.
`timescale 1ns/1ps
module pwm_scheduler
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int NUM_OUT = pwm_pkg::NUM_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         en_reg_out_7_0,
    input  logic [7:0]         en_reg_out_15_8,
    input  logic [7:0]         en_reg_pwm_7_0,
    input  logic [7:0]         en_reg_pwm_15_8,
    input  logic [7:0]         pwm_duty_cycle,
    output logic [NUM_OUT-1:0] out,
    output logic               period_start,
    output logic               duty_pending
);

    logic [NUM_OUT-1:0]   r_en_out;
    logic [NUM_OUT-1:0]   r_en_pwm;
    logic [PWM_CNT_W-1:0] r_active_duty;
    logic                 r_period_start;
    logic                 r_duty_pending;
    logic [NUM_OUT-1:0]   r_out;

    logic [PWM_CNT_W-1:0] w_cnt;
    logic                 w_wrap;
    logic                 w_level;
    logic [NUM_OUT-1:0]   w_out_next;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    assign w_level = pwm_level_f(w_cnt, r_active_duty);

    // Enables are sampled once; they are not shadowed, so static changes show up after two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= '0;
            r_en_pwm <= '0;
        end else begin
            r_en_out <= {en_reg_out_15_8, en_reg_out_7_0};
            r_en_pwm <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
        end
    end

    // Duty shadow: the value present on the wrap clock becomes the next period's duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_duty <= '0;
        end else if (w_wrap) begin
            r_active_duty <= pwm_duty_cycle;
        end
    end

    // Status flags: boundary pulse lands in the first cnt==0 clock; pending tracks an unapplied duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_start <= 1'b0;
            r_duty_pending <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            r_duty_pending <= (pwm_duty_cycle != r_active_duty);
        end
    end

    // Per-output select: disabled -> 0, static mode -> 1, PWM mode -> current level.
    always_comb begin
        w_out_next = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (r_en_out[i]) begin
                w_out_next[i] = r_en_pwm[i] ? w_level : 1'b1;
            end
        end
    end

    // Registered outputs keep the pins free of compare glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
    assign duty_pending = r_duty_pending;

endmodule

// File: tb/tb_pwm_scheduler.sv
// Bench for pwm_scheduler with CLK_DIV=4 (1024-clock period). Expected values come
// from a cycle-indexed arithmetic model: the PWM position is derived from the number
// of clocks since reset, not from any counter in the design.
`timescale 1ns/1ps
module tb_pwm_scheduler;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 256 * CLK_DIV;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] dut_out;
    logic        ps, pend;

    always #5 clk = ~clk;

    pwm_scheduler #(
        .CLK_DIV (CLK_DIV),
        .NUM_OUT (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (dut_out),
        .period_start    (ps),
        .duty_pending    (pend)
    );

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    int          k;          // clock edges since reset release
    logic [7:0]  m_act;      // duty in force for the current period
    logic [15:0] m_en_out, m_en_pwm;
    logic [15:0] exp_out;
    logic        exp_ps, exp_pend;

    int hi_cnt [16];
    int ps_cnt, pend_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        m_act    = 8'h00;
        m_en_out = 16'h0000;
        m_en_pwm = 16'h0000;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
        ps_cnt   = 0;
        pend_cnt = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        eo_lo = eo[7:0];
        eo_hi = eo[15:8];
        ep_lo = ep[7:0];
        ep_hi = ep[15:8];
    endtask

    // One clock: advance the model by the edge, then compare every output.
    task automatic step();
        int   pos_prev;
        int   cnt_prev;
        logic lvl;
        @(posedge clk);
        #1;
        k++;
        // Outputs after edge k reflect the PWM position before that edge.
        pos_prev = (k - 1) % PERIOD;
        cnt_prev = pos_prev / CLK_DIV;
        if (m_act == 8'hFF) lvl = 1'b1;
        else                lvl = (cnt_prev < int'(m_act));
        for (int i = 0; i < 16; i++) begin
            if (!m_en_out[i])     exp_out[i] = 1'b0;
            else if (m_en_pwm[i]) exp_out[i] = lvl;
            else                  exp_out[i] = 1'b1;
        end
        exp_ps   = ((k % PERIOD) == 0);
        exp_pend = (duty != m_act);
        if (exp_ps) m_act = duty;
        m_en_out = {eo_hi, eo_lo};
        m_en_pwm = {ep_hi, ep_lo};

        check_eq("out", dut_out, exp_out);
        check_eq("period_start", ps, exp_ps);
        check_eq("duty_pending", pend, exp_pend);

        for (int i = 0; i < 16; i++) if (dut_out[i]) hi_cnt[i]++;
        if (ps)   ps_cnt++;
        if (pend) pend_cnt++;
    endtask

    // Step until the DUT shows a period boundary, bounded by two periods.
    task automatic wait_ps();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2 * PERIOD && !seen; n++) begin
            step();
            if (ps) seen = 1'b1;
        end
        check_eq("wait_period_start", seen, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        duty  = 8'h00;
        set_en(16'h0000, 16'h0000);
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", dut_out, 16'h0000);
        check_eq("reset_period_start", ps, 1'b0);
        check_eq("reset_duty_pending", pend, 1'b0);
        rst_n = 1'b1;

        // 1. Static mode: two clocks from enable write to pin.
        set_en(16'hFF00, 16'h0000);
        step();
        check_eq("static_after_1clk", dut_out, 16'h0000);
        step();
        check_eq("static_on_2clk", dut_out, 16'hFF00);
        set_en(16'h0000, 16'h0000);
        step();
        check_eq("static_off_1clk", dut_out, 16'hFF00);
        step();
        check_eq("static_off_2clk", dut_out, 16'h0000);

        // 2. 50% duty on output 0.
        duty = 8'h80;
        set_en(16'h0001, 16'h0001);
        wait_ps();
        for (int p = 0; p < 2; p++) begin
            clear_counts();
            repeat (PERIOD) step();
            check_eq("duty80_high_clks", hi_cnt[0], 512);
            check_eq("duty80_period_starts", ps_cnt, 1);
        end

        // 3. Duty extremes over three periods each.
        duty = 8'h00;
        wait_ps();
        clear_counts();
        repeat (3 * PERIOD) step();
        check_eq("duty00_high_clks", hi_cnt[0], 0);
        duty = 8'hFF;
        wait_ps();
        clear_counts();
        repeat (3 * PERIOD) step();
        check_eq("dutyFF_high_clks", hi_cnt[0], 3 * PERIOD);

        // 4. Shadowing: change 0x40 -> 0xC0 while cnt==0x10.
        duty = 8'h40;
        wait_ps();
        clear_counts();
        repeat (16 * CLK_DIV) step();
        duty = 8'hC0;
        repeat (PERIOD - 16 * CLK_DIV) step();
        check_eq("shadow_cur_high_clks", hi_cnt[0], 256);
        check_eq("shadow_pending_clks", pend_cnt, PERIOD - 16 * CLK_DIV);
        clear_counts();
        repeat (PERIOD) step();
        check_eq("shadow_next_high_clks", hi_cnt[0], 768);
        check_eq("shadow_next_pending_clks", pend_cnt, 0);

        // 5. Asynchronous reset at cnt==0x90 with duty 0x80.
        duty = 8'h80;
        wait_ps();
        repeat (8'h90 * CLK_DIV) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_out", dut_out, 16'h0000);
        check_eq("rst_mid_period_start", ps, 1'b0);
        check_eq("rst_mid_duty_pending", pend, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        repeat (PERIOD) step();
        check_eq("rst_first_period_high", hi_cnt[0], 0);
        check_eq("rst_first_period_starts", ps_cnt, 1);
        clear_counts();
        repeat (PERIOD) step();
        check_eq("rst_second_period_high", hi_cnt[0], 512);

        // 6. Mixed static and PWM outputs.
        set_en(16'hFFFF, 16'h00FF);
        duty = 8'h20;
        wait_ps();
        clear_counts();
        repeat (PERIOD) step();
        check_eq("mixed_bit0_high", hi_cnt[0], 128);
        check_eq("mixed_bit7_high", hi_cnt[7], 128);
        check_eq("mixed_bit8_high", hi_cnt[8], PERIOD);
        check_eq("mixed_bit15_high", hi_cnt[15], PERIOD);

        // Duty change landing exactly on the wrap clock is captured.
        duty = 8'h55;
        wait_ps();
        repeat (PERIOD - 1) step();
        duty = 8'h33;
        step();
        check_eq("wrap_edge_period_start", ps, 1'b1);
        clear_counts();
        repeat (PERIOD) step();
        check_eq("wrap_edge_high_clks", hi_cnt[0], 8'h33 * CLK_DIV);

        // Random enables and duty changes against the model.
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                case ($urandom_range(0, 3))
                    0:       duty = 8'h00;
                    1:       duty = 8'hFF;
                    default: duty = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                set_en(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
